// File: rtl/avalon_st_operand_master.sv
// avalon_st_operand_master
// Avalon-ST master: sends NUM_OPS operands as framed symbol packets
// (header k+1 with SOP, payload MSB first, EOP on the last symbol) and
// collects one RES_W-bit result packet, reporting framing errors on err.
// Optional feature macro: AVST_CHECKSUM_EN. When defined, each TX packet
// carries a trailing XOR checksum symbol and each RX packet must end in one.
module avalon_st_operand_master #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 32,
    parameter int NUM_OPS = 2,
    parameter int RES_W   = 64
) (
    input  logic                    clk_in,
    input  logic                    rst,
    output logic                    clk_out,
    input  logic                    start,
    input  logic [NUM_OPS*OP_W-1:0] ops_in,
    output logic                    busy,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    output logic                    startofpacket_out,
    output logic                    endofpacket_out,
    input  logic                    ready_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    valid_in,
    input  logic                    startofpacket_in,
    input  logic                    endofpacket_in,
    output logic                    ready_out,
    output logic [RES_W-1:0]        RES,
    output logic                    ready_res,
    output logic                    err
);

    localparam int PAY_BEATS = OP_W / DATA_W;
`ifdef AVST_CHECKSUM_EN
    localparam int RX_BEATS  = RES_W / DATA_W + 1;
`else
    localparam int RX_BEATS  = RES_W / DATA_W;
`endif
    localparam int OPI_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int BI_W  = $clog2(PAY_BEATS + 2) + 1;
    localparam int CNT_W = $clog2(RX_BEATS + 1) + 1;

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_HDR     = 2'd1;
    localparam logic [1:0] TX_PAYLOAD = 2'd2;
    localparam logic       RX_WAIT_SOP = 1'b0;
    localparam logic       RX_COLLECT  = 1'b1;

    // ---------------- transmit side ----------------
    logic [1:0]              tx_state_r, tx_state_s;
    logic [OPI_W-1:0]        op_idx_r, op_idx_s;
    logic [BI_W-1:0]         beat_r, beat_s;
    logic [NUM_OPS*OP_W-1:0] ops_r;
    logic                    load_ops_s;
    logic [DATA_W-1:0]       data_out_r, data_s;
    logic                    valid_out_r, valid_s;
    logic                    sop_r, sop_s, eop_r, eop_s;
    logic                    busy_r, busy_s;
    logic [OP_W-1:0]         op_s;
    logic [DATA_W-1:0]       pay_sym_s, hdr_nxt_s;
    int                      sh_s;
`ifdef AVST_CHECKSUM_EN
    logic [DATA_W-1:0]       csum_r, csum_s;
`endif

    assign clk_out           = clk_in;
    assign busy              = busy_r;
    assign data_out          = data_out_r;
    assign valid_out         = valid_out_r;
    assign startofpacket_out = sop_r;
    assign endofpacket_out   = eop_r;

    // Select the payload symbol that follows the current beat (MSB first)
    always_comb begin
        op_s = OP_W'(ops_r >> (int'(op_idx_r) * OP_W));
        if (int'(beat_r) < PAY_BEATS) begin
            sh_s = (PAY_BEATS - 1 - int'(beat_r)) * DATA_W;
        end else begin
            sh_s = 0;
        end
        pay_sym_s = DATA_W'(op_s >> sh_s);
        hdr_nxt_s = DATA_W'(op_idx_r) + DATA_W'(2);
    end

    // TX next-state: next beat is prepared only when the current one transfers
    always_comb begin
        tx_state_s = tx_state_r;
        op_idx_s   = op_idx_r;
        beat_s     = beat_r;
        data_s     = data_out_r;
        valid_s    = valid_out_r;
        sop_s      = sop_r;
        eop_s      = eop_r;
        busy_s     = busy_r;
        load_ops_s = 1'b0;
`ifdef AVST_CHECKSUM_EN
        csum_s     = csum_r;
`endif
        case (tx_state_r)
            TX_IDLE: begin
                if (start) begin
                    load_ops_s = 1'b1;
                    tx_state_s = TX_HDR;
                    op_idx_s   = '0;
                    beat_s     = '0;
                    data_s     = DATA_W'(1);
                    valid_s    = 1'b1;
                    sop_s      = 1'b1;
                    eop_s      = 1'b0;
                    busy_s     = 1'b1;
`ifdef AVST_CHECKSUM_EN
                    csum_s     = DATA_W'(1);
`endif
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_HDR, TX_PAYLOAD: begin
                if (valid_out_r && ready_in) begin
                    if (eop_r) begin
                        if (op_idx_r == OPI_W'(NUM_OPS - 1)) begin
                            tx_state_s = TX_IDLE;
                            data_s     = '0;
                            valid_s    = 1'b0;
                            sop_s      = 1'b0;
                            eop_s      = 1'b0;
                            busy_s     = 1'b0;
                        end else begin
                            tx_state_s = TX_HDR;
                            op_idx_s   = op_idx_r + 1'b1;
                            beat_s     = '0;
                            data_s     = hdr_nxt_s;
                            sop_s      = 1'b1;
                            eop_s      = 1'b0;
`ifdef AVST_CHECKSUM_EN
                            csum_s     = hdr_nxt_s;
`endif
                        end
                    end else begin
                        tx_state_s = TX_PAYLOAD;
                        beat_s     = beat_r + 1'b1;
                        sop_s      = 1'b0;
`ifdef AVST_CHECKSUM_EN
                        if (beat_r == BI_W'(PAY_BEATS)) begin
                            data_s = csum_r;
                            eop_s  = 1'b1;
                        end else begin
                            data_s = pay_sym_s;
                            csum_s = csum_r ^ pay_sym_s;
                            eop_s  = 1'b0;
                        end
`else
                        data_s = pay_sym_s;
                        eop_s  = (beat_r == BI_W'(PAY_BEATS - 1));
`endif
                    end
                end else begin
                    tx_state_s = tx_state_r;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                data_s     = '0;
                valid_s    = 1'b0;
                sop_s      = 1'b0;
                eop_s      = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // TX state and registered stream outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tx_state_r  <= TX_IDLE;
            op_idx_r    <= '0;
            beat_r      <= '0;
            ops_r       <= '0;
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            busy_r      <= 1'b0;
`ifdef AVST_CHECKSUM_EN
            csum_r      <= '0;
`endif
        end else begin
            tx_state_r  <= tx_state_s;
            op_idx_r    <= op_idx_s;
            beat_r      <= beat_s;
            ops_r       <= load_ops_s ? ops_in : ops_r;
            data_out_r  <= data_s;
            valid_out_r <= valid_s;
            sop_r       <= sop_s;
            eop_r       <= eop_s;
            busy_r      <= busy_s;
`ifdef AVST_CHECKSUM_EN
            csum_r      <= csum_s;
`endif
        end
    end

    // ---------------- receive side ----------------
    logic               rx_state_r, rx_state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, nxt_cnt_s;
    logic [RES_W-1:0]   shift_r, shift_s, base_s;
    logic [RES_W-1:0]   res_r, res_s;
    logic               ready_out_r, ready_res_r, res_pulse_s, err_r, err_s;
    logic               take_s, ck_ok_s;
`ifdef AVST_CHECKSUM_EN
    logic [DATA_W-1:0]  xr_r, xr_s, xbase_s;
`endif

    assign ready_out = ready_out_r;
    assign RES       = res_r;
    assign ready_res = ready_res_r;
    assign err       = err_r;

    // RX framing: collect symbols, validate length/EOP/SOP (and checksum)
    always_comb begin
        rx_state_s  = rx_state_r;
        cnt_s       = cnt_r;
        shift_s     = shift_r;
        res_s       = res_r;
        res_pulse_s = 1'b0;
        err_s       = 1'b0;
        take_s      = 1'b0;
        base_s      = shift_r;
        nxt_cnt_s   = cnt_r + 1'b1;
        ck_ok_s     = 1'b1;
`ifdef AVST_CHECKSUM_EN
        xr_s        = xr_r;
        xbase_s     = xr_r;
`endif
        if (valid_in && ready_out_r) begin
            if (startofpacket_in) begin
                take_s    = 1'b1;
                err_s     = (rx_state_r == RX_COLLECT);
                base_s    = '0;
                nxt_cnt_s = CNT_W'(1);
`ifdef AVST_CHECKSUM_EN
                xbase_s   = '0;
`endif
            end else if (rx_state_r == RX_COLLECT) begin
                take_s = 1'b1;
            end else begin
                take_s = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end

        if (take_s) begin
            cnt_s      = nxt_cnt_s;
            rx_state_s = RX_COLLECT;
`ifdef AVST_CHECKSUM_EN
            if (nxt_cnt_s == CNT_W'(RX_BEATS)) begin
                ck_ok_s = (xbase_s == data_in);
                shift_s = shift_r;
            end else begin
                shift_s = RES_W'({base_s, data_in});
                xr_s    = xbase_s ^ data_in;
            end
`else
            shift_s = RES_W'({base_s, data_in});
`endif
            if (endofpacket_in) begin
                rx_state_s = RX_WAIT_SOP;
                cnt_s      = '0;
                if ((nxt_cnt_s == CNT_W'(RX_BEATS)) && ck_ok_s) begin
                    res_s       = shift_s;
                    res_pulse_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end else if (nxt_cnt_s == CNT_W'(RX_BEATS)) begin
                rx_state_s = RX_WAIT_SOP;
                cnt_s      = '0;
                err_s      = 1'b1;
            end else begin
                rx_state_s = RX_COLLECT;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // RX state, result register and one-cycle status pulses
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rx_state_r  <= RX_WAIT_SOP;
            cnt_r       <= '0;
            shift_r     <= '0;
            res_r       <= '0;
            ready_out_r <= 1'b0;
            ready_res_r <= 1'b0;
            err_r       <= 1'b0;
`ifdef AVST_CHECKSUM_EN
            xr_r        <= '0;
`endif
        end else begin
            rx_state_r  <= rx_state_s;
            cnt_r       <= cnt_s;
            shift_r     <= shift_s;
            res_r       <= res_s;
            ready_out_r <= 1'b1;
            ready_res_r <= res_pulse_s;
            err_r       <= err_s;
`ifdef AVST_CHECKSUM_EN
            xr_r        <= xr_s;
`endif
        end
    end

endmodule

// File: tb/tb_avalon_st_operand_master.sv
// Self-checking bench for avalon_st_operand_master: a queue-based model of
// the expected TX beats and RX results is compared on every falling edge,
// plus literal checks of the documented example sequences.
module tb_avalon_st_operand_master;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 32;
    localparam int NUM_OPS = 2;
    localparam int RES_W   = 64;
    localparam int PB      = OP_W / DATA_W;
    localparam int NB_RES  = RES_W / DATA_W;
`ifdef AVST_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int NBX = NB_RES + (CK ? 1 : 0);

    logic                    clk_in, rst, clk_out, start, busy;
    logic [NUM_OPS*OP_W-1:0] ops_in;
    logic [DATA_W-1:0]       data_out, data_in;
    logic                    valid_out, startofpacket_out, endofpacket_out, ready_in;
    logic                    valid_in, startofpacket_in, endofpacket_in, ready_out;
    logic [RES_W-1:0]        RES;
    logic                    ready_res, err;

    avalon_st_operand_master #(.DATA_W(DATA_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .RES_W(RES_W)) dut (
        .clk_in(clk_in), .rst(rst), .clk_out(clk_out), .start(start), .ops_in(ops_in),
        .busy(busy), .data_out(data_out), .valid_out(valid_out),
        .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
        .ready_in(ready_in), .data_in(data_in), .valid_in(valid_in),
        .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
        .ready_out(ready_out), .RES(RES), .ready_res(ready_res), .err(err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed { logic [7:0] d; logic sop; logic eop; } beat_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int stall_cnt = 0, rdy_cnt = 0, err_cnt = 0;
    beat_t txq[$];
    logic [7:0] rxq[$];
    bit in_pkt = 1'b0;
    logic [RES_W-1:0] m_res = '0;
    bit m_rdy = 1'b0, m_err = 1'b0, m_rdy_out = 1'b0;
    logic [7:0] log_d[$];
    int log_c[$];
    logic [7:0] exp_seq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat list of a whole transaction, built straight from the framing rules
    task automatic push_ops(input logic [NUM_OPS*OP_W-1:0] ops);
        for (int k = 0; k < NUM_OPS; k++) begin
            logic [OP_W-1:0] op;
            logic [7:0] x, b;
            op = ops[k*OP_W +: OP_W];
            x = 8'(k + 1);
            txq.push_back('{d: 8'(k + 1), sop: 1'b1, eop: 1'b0});
            for (int j = 0; j < PB; j++) begin
                b = op[OP_W-1-DATA_W*j -: DATA_W];
                x = x ^ b;
                txq.push_back('{d: b, sop: 1'b0, eop: (!CK && j == PB - 1)});
            end
            if (CK) txq.push_back('{d: x, sop: 1'b0, eop: 1'b1});
        end
    endtask

    task automatic rx_model(input logic [7:0] d, input logic s, input logic e);
        logic [RES_W-1:0] r;
        logic [7:0] x;
        if (s) begin
            if (in_pkt) m_err = 1'b1;
            rxq.delete();
            rxq.push_back(d);
            in_pkt = 1'b1;
        end else if (in_pkt) begin
            rxq.push_back(d);
        end else begin
            return;
        end
        if (rxq.size() == NBX) begin
            r = '0; x = '0;
            for (int i = 0; i < NB_RES; i++) begin
                r = (r << DATA_W) | RES_W'(rxq[i]);
                x = x ^ rxq[i];
            end
            if (e && (!CK || x == rxq[NB_RES])) begin
                m_res = r;
                m_rdy = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            in_pkt = 1'b0;
        end else if (e) begin
            m_err = 1'b1;
            in_pkt = 1'b0;
        end
    endtask

    // Model update on every rising edge / asynchronous reset
    initial forever begin
        @(posedge clk_in or negedge rst);
        if (!rst) begin
            txq.delete(); rxq.delete(); in_pkt = 1'b0;
            m_res = '0; m_rdy = 1'b0; m_err = 1'b0; m_rdy_out = 1'b0;
        end else begin
            m_rdy = 1'b0; m_err = 1'b0;
            if (txq.size() > 0) begin
                if (ready_in) void'(txq.pop_front());
            end else if (start) begin
                push_ops(ops_in);
            end
            if (valid_in && m_rdy_out) rx_model(data_in, startofpacket_in, endofpacket_in);
            m_rdy_out = 1'b1;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    initial forever begin
        @(negedge clk_in);
        cyc++;
        check("valid_out", valid_out, txq.size() > 0);
        check("busy", busy, txq.size() > 0);
        if (valid_out && txq.size() > 0) begin
            check("data_out", data_out, txq[0].d);
            check("sop_out", startofpacket_out, txq[0].sop);
            check("eop_out", endofpacket_out, txq[0].eop);
        end
        check("ready_out", ready_out, m_rdy_out);
        check("RES", RES, m_res);
        check("ready_res", ready_res, m_rdy);
        check("err", err, m_err);
        check("clk_out", clk_out, clk_in);
        if (valid_out && ready_in) begin log_d.push_back(data_out); log_c.push_back(cyc); end
        if (valid_out && data_out == 8'h22) stall_cnt++;
        if (ready_res) rdy_cnt++;
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!busy) break;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (valid_out && data_out == b) break;
        end
        check("byte_seen", (valid_out && data_out == b), 1'b1);
    endtask

    task automatic send_ab();
        ops_in = {32'hAABBCCDD, 32'h11223344};
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, log_d.size(), exp_seq.size());
        if (log_d.size() == exp_seq.size()) begin
            for (int i = 0; i < exp_seq.size(); i++) check(name, log_d[i], exp_seq[i]);
        end
    endtask

    task automatic rx_beat(input logic [7:0] d, input logic s, input logic e);
        data_in = d; startofpacket_in = s; endofpacket_in = e; valid_in = 1'b1;
        tick();
        valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    endtask

    task automatic rx_good(input logic [63:0] v, input bit corrupt);
        logic [7:0] x, b;
        x = '0;
        for (int i = 0; i < NB_RES; i++) begin
            b = v[63-8*i -: 8];
            x = x ^ b;
            rx_beat(b, i == 0, (!CK && i == NB_RES - 1));
        end
        if (CK) rx_beat(corrupt ? ~x : x, 1'b0, 1'b1);
    endtask

    initial begin
`ifdef AVST_CHECKSUM_EN
        exp_seq = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
`else
        exp_seq = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif
        rst = 1'b0; start = 1'b0; ops_in = '0; ready_in = 1'b1;
        data_in = '0; valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_valid", valid_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready_out", ready_out, 1'b0);
        check("rst_RES", RES, 64'h0);
        check("rst_data", data_out, 8'h00);
        tick(); rst = 1'b1; tick();

        // Back-to-back transaction at full throughput
        log_d.delete(); log_c.delete();
        send_ab(); wait_idle(100);
        check_seq("t1_seq");
        if (log_c.size() == exp_seq.size())
            check("t1_consecutive", log_c[log_c.size()-1] - log_c[0], exp_seq.size() - 1);

        // Backpressure while 0x22 is presented
        log_d.delete(); stall_cnt = 0;
        send_ab(); wait_byte(8'h22);
        ready_in = 1'b0; repeat (3) tick(); ready_in = 1'b1;
        wait_idle(100);
        check_seq("t2_seq");
        check("t2_hold", stall_cnt, 4);

        // Good RX packet
        rdy_cnt = 0; err_cnt = 0;
        rx_good(64'h0102030405060708, 1'b0); repeat (2) tick();
        check("t3_RES", RES, 64'h0102030405060708);
        check("t3_rdy_once", rdy_cnt, 1);
        check("t3_no_err", err_cnt, 0);

        // Early EOP on beat 5
        err_cnt = 0;
        rx_beat(8'h01, 1'b1, 1'b0); rx_beat(8'h02, 1'b0, 1'b0); rx_beat(8'h03, 1'b0, 1'b0);
        rx_beat(8'h04, 1'b0, 1'b0); rx_beat(8'h05, 1'b0, 1'b1); repeat (2) tick();
        check("t4_err", err_cnt, 1);
        check("t4_RES_kept", RES, 64'h0102030405060708);

        // SOP on beat 3 restarts collection
        err_cnt = 0; rdy_cnt = 0;
        rx_beat(8'h01, 1'b1, 1'b0); rx_beat(8'h02, 1'b0, 1'b0);
        rx_good(64'h1112131415161718, 1'b0); repeat (2) tick();
        check("t4b_err", err_cnt, 1);
        check("t4b_RES", RES, 64'h1112131415161718);
        check("t4b_rdy", rdy_cnt, 1);

`ifdef AVST_CHECKSUM_EN
        // Corrupted checksum must be rejected
        err_cnt = 0;
        rx_good(64'h2122232425262728, 1'b1); repeat (2) tick();
        check("ck_err", err_cnt, 1);
        check("ck_RES_kept", RES, 64'h1112131415161718);
`endif

        // Asynchronous reset in the middle of operand B
        send_ab(); wait_byte(8'hAA);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", valid_out, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_data", data_out, 8'h00);
        check("ar_sop_eop", {startofpacket_out, endofpacket_out}, 2'b00);
        check("ar_RES", RES, 64'h0);
        check("ar_ready_out", ready_out, 1'b0);
        tick(); tick(); rst = 1'b1; tick();
        log_d.delete();
        send_ab(); wait_idle(100);
        check_seq("t5_seq");

        // Randomized concurrent TX and RX traffic
        fork
            begin
                for (int t = 0; t < 20; t++) begin
                    ops_in = {$urandom, $urandom};
                    start = 1'b1; tick();
                    for (int k = 0; k < 300; k++) begin
                        ready_in = ($urandom_range(0, 3) != 0);
                        start = ($urandom_range(0, 7) == 0);
                        ops_in = {$urandom, $urandom};
                        tick();
                        if (!busy) break;
                    end
                end
                start = 1'b0; ready_in = 1'b1;
                wait_idle(100);
            end
            begin
                for (int r = 0; r < 40; r++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rx_good({$urandom, $urandom}, ($urandom_range(0, 3) == 0));
                    end else begin
                        for (int q = 0; q < 8; q++) begin
                            if ($urandom_range(0, 3) == 0) tick();
                            else rx_beat(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
                        end
                    end
                end
            end
        join
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
